wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ex_valid  input  1  execute stage offers a completed instruction.
REQ-005 SHALL have port ex_ready  output  1  stage accepts the offer this cycle.
REQ-006 SHALL have port ex_rd  input  5  destination register.
REQ-007 SHALL have port ex_result  input  32  ALU result, or the load address for loads.
REQ-008 SHALL have port ex_is_load  input  1  instruction is a load.
REQ-009 SHALL have port ex_funct3  input  3  load size/sign encoding.
REQ-010 SHALL have port dmem_rvalid  input  1  data-memory read response valid.
REQ-011 SHALL have port dmem_rdata  input  32  data-memory read word (word-aligned).
REQ-012 SHALL have port rf_we  output  1  register-file write enable.
REQ-013 SHALL have port rf_waddr  output  5  register-file write address.
REQ-014 SHALL have port rf_wdata  output  32  register-file write data.
REQ-015 SHALL have port instret  output  32  retired-instruction count.
REQ-016 SHALL have port proto_err  output  1  sticky flag: dmem_rvalid seen while no load is outstanding.

Function
REQ-017 SHALL implement FSM states IDLE and WAIT_LOAD.
REQ-018 SHALL drive ex_ready = 1 only in IDLE; a transfer is ex_valid && ex_ready at a rising edge.
REQ-019 SHALL, on a non-load transfer at edge N: assert rf_we for exactly cycle N+1 with rf_waddr = ex_rd and rf_wdata = ex_result; stay in IDLE.
REQ-020 SHALL, on a load transfer: latch ex_rd, ex_funct3 and ex_result[1:0]; go to WAIT_LOAD.
REQ-021 SHALL, in WAIT_LOAD with dmem_rvalid sampled at edge M, assert rf_we in cycle M+1 with aligned data and return to IDLE; ex_ready SHALL therefore first rise in cycle M+1.
REQ-022 SHALL select and extend load data as follows:
  - LB (000): byte at offset addr_lo, sign-extended.
  - LBU (100): byte at offset addr_lo, zero-extended.
  - LH (001): halfword selected by addr_lo[1], sign-extended.
  - LHU (101): halfword selected by addr_lo[1], zero-extended.
  - LW (010), and any other funct3: full word.
REQ-023 SHALL leave rf_we = 0 in every cycle that is not a completion cycle defined by REQ-019 or REQ-021.
REQ-024 SHALL force rf_we = 0 when rd = 0; the instruction still retires.
REQ-025 SHALL increment instret by 1 in each completion cycle, including rd = 0, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL ignore dmem_rvalid while in IDLE, set proto_err, and hold proto_err until reset.
REQ-027 SHALL hold rf_waddr/rf_wdata at their last values when rf_we = 0.
REQ-028 SHALL remain in WAIT_LOAD indefinitely while dmem_rvalid = 0; no timeout.

Reset
REQ-029 SHALL, while rst = 1: state = IDLE; rf_we = 0; rf_waddr = 0; rf_wdata = 0; instret = 0; proto_err = 0; ex_ready = 1 once rst deasserts.
REQ-030 SHALL discard an outstanding load on rst asserted in WAIT_LOAD, with no write and no retire.

Structure
REQ-031 SHALL take load funct3 encodings and the wb_state_t enum from shared package rv32_pkg.
REQ-032 SHALL place extraction and extension in combinational sub-module load_align (inputs rdata, funct3, addr_lo; output 32-bit data).

Verification
REQ-033 SHALL verify: non-load rd=5, result=0x12345678 accepted at edge N -> rf_we=1, waddr=5, wdata=0x12345678 in cycle N+1 only; instret=1.
REQ-034 SHALL verify: LB rd=3, addr_lo=2, dmem_rdata=0x00800000 -> wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SHALL verify: LH addr_lo=2, rdata=0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x8001ABCD.
REQ-036 SHALL verify: load with rvalid delayed 5 cycles -> ex_ready=0 for those cycles while ex_valid is held; write in the cycle after rvalid; the next instruction is accepted that same cycle.
REQ-037 SHALL verify: non-load with rd=0 -> rf_we stays 0 and instret increments; rvalid pulsed in IDLE -> proto_err=1 and stays set.
REQ-038 SHALL verify: rst asserted in WAIT_LOAD then rvalid -> no write, instret=0, state IDLE; instret preset near wrap by 2 retirements from 0xFFFFFFFF -> 0x00000001.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the writeback stage: load encodings, FSM states, load context.
package rv32_pkg;

  localparam int unsigned XLEN_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned F3_W    = 3;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  // Context captured when a load is accepted, consumed when its data returns.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [F3_W-1:0]   funct3;
    logic [1:0]        addr_lo;
  } ld_ctx_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a word-aligned read and sign/zero-extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [XLEN_W-1:0] rdata,
  input  logic [F3_W-1:0]   funct3,
  input  logic [1:0]        addr_lo,
  output logic [XLEN_W-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data   = rdata;
    case (funct3)
      F3_LB:   data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  data = {24'd0, byte_v};
      F3_LH:   data = {{16{half_v[15]}}, half_v};
      F3_LHU:  data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and parks on loads until dmem data returns.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              ex_is_load,
  input  logic [F3_W-1:0]   ex_funct3,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [31:0]       instret,
  output logic              proto_err
);

  wb_state_t         state_q, state_d;
  ld_ctx_t           ld_q, ld_d;
  logic              ex_ready_q, ex_ready_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [31:0]       instret_q, instret_d;
  logic              proto_err_q, proto_err_d;
  logic [XLEN-1:0]   load_data_c;

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .funct3  (ld_q.funct3),
    .addr_lo (ld_q.addr_lo),
    .data    (load_data_c)
  );

  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    instret_d   = instret_q;
    proto_err_d = proto_err_q;

    case (state_q)
      IDLE: begin
        if (dmem_rvalid) proto_err_d = 1'b1;
        if (ex_valid) begin
          if (ex_is_load) begin
            ld_d.rd      = ex_rd;
            ld_d.funct3  = ex_funct3;
            ld_d.addr_lo = ex_result[1:0];
            state_d      = WAIT_LOAD;
          end else begin
            instret_d = instret_q + 32'd1;
            // x0 retires but never writes, and the write port keeps its last values
            if (ex_rd != '0) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = ex_rd;
              rf_wdata_d = ex_result;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          instret_d = instret_q + 32'd1;
          state_d   = IDLE;
          if (ld_q.rd != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_q.rd;
            rf_wdata_d = load_data_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ex_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ld_q        <= '0;
      ex_ready_q  <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      instret_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      ex_ready_q  <= ex_ready_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      instret_q   <= instret_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ex_ready  = ex_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign instret   = instret_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/load writeback, alignment, stalls, x0, protocol error, reset, wrap.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] instret;
  logic        proto_err;

  int n_vec;
  int n_err;

  wb_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rd       (ex_rd),
    .ex_result   (ex_result),
    .ex_is_load  (ex_is_load),
    .ex_funct3   (ex_funct3),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .instret     (instret),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] res,
                       input logic is_load, input logic [2:0] f3);
    ex_valid   = 1'b1;
    ex_rd      = rd;
    ex_result  = res;
    ex_is_load = is_load;
    ex_funct3  = f3;
    tick();
    ex_valid   = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    dmem_rvalid = 1'b1;
    dmem_rdata  = data;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] data, input logic [31:0] exp,
                           input logic [31:0] exp_ret);
    issue(5'd3, {30'h0000_0400, lo}, 1'b1, f3);
    check({tag, "_stall"}, {31'd0, ex_ready}, 32'd0);
    respond(data);
    check({tag, "_we"}, {31'd0, rf_we}, 32'd1);
    check({tag, "_wdata"}, rf_wdata, exp);
    check({tag, "_ret"}, instret, exp_ret);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    ex_valid    = 1'b0;
    ex_rd       = 5'd0;
    ex_result   = 32'd0;
    ex_is_load  = 1'b0;
    ex_funct3   = 3'd0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;

    tick();
    tick();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_perr", {31'd0, proto_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", {31'd0, ex_ready}, 32'd1);

    // ALU result writes for exactly one cycle, then the port holds its values
    issue(5'd5, 32'h1234_5678, 1'b0, 3'd0);
    check("alu_we", {31'd0, rf_we}, 32'd1);
    check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    check("alu_wdata", rf_wdata, 32'h1234_5678);
    check("alu_ret", instret, 32'd1);
    tick();
    check("alu_we_off", {31'd0, rf_we}, 32'd0);
    check("alu_hold_wa", {27'd0, rf_waddr}, 32'd5);
    check("alu_hold_wd", rf_wdata, 32'h1234_5678);

    load_case("lb",   3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 32'd2);
    check("lb_waddr", {27'd0, rf_waddr}, 32'd3);
    load_case("lbu",  3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080, 32'd3);
    load_case("lh",   3'b001, 2'd2, 32'h8001_ABCD, 32'hFFFF_8001, 32'd4);
    load_case("lhu",  3'b101, 2'd2, 32'h8001_ABCD, 32'h0000_8001, 32'd5);
    load_case("lw",   3'b010, 2'd2, 32'h8001_ABCD, 32'h8001_ABCD, 32'd6);
    load_case("lh0",  3'b001, 2'd0, 32'h8001_ABCD, 32'hFFFF_ABCD, 32'd7);
    load_case("lb1",  3'b000, 2'd1, 32'h8001_ABCD, 32'hFFFF_FFAB, 32'd8);
    load_case("lbu3", 3'b100, 2'd3, 32'h8001_ABCD, 32'h0000_0080, 32'd9);
    load_case("f3_3", 3'b011, 2'd1, 32'h8001_ABCD, 32'h8001_ABCD, 32'd10);

    // Load with a 5-cycle data delay while the next instruction is held on the input
    ex_valid   = 1'b1;
    ex_rd      = 5'd7;
    ex_result  = 32'h0000_0100;
    ex_is_load = 1'b1;
    ex_funct3  = 3'b010;
    tick();
    ex_rd      = 5'd9;
    ex_result  = 32'h0000_CAFE;
    ex_is_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_ready%0d", i), {31'd0, ex_ready}, 32'd0);
      check($sformatf("stall_we%0d", i), {31'd0, rf_we}, 32'd0);
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    check("dly_we", {31'd0, rf_we}, 32'd1);
    check("dly_waddr", {27'd0, rf_waddr}, 32'd7);
    check("dly_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("dly_ready", {31'd0, ex_ready}, 32'd1);
    check("dly_ret", instret, 32'd11);
    tick();
    ex_valid = 1'b0;
    check("next_we", {31'd0, rf_we}, 32'd1);
    check("next_waddr", {27'd0, rf_waddr}, 32'd9);
    check("next_wdata", rf_wdata, 32'h0000_CAFE);
    check("next_ret", instret, 32'd12);

    // x0 destination retires without writing, for both ALU and load
    issue(5'd0, 32'h5555_AAAA, 1'b0, 3'd0);
    check("x0_we", {31'd0, rf_we}, 32'd0);
    check("x0_ret", instret, 32'd13);
    check("x0_hold_wa", {27'd0, rf_waddr}, 32'd9);
    check("x0_hold_wd", rf_wdata, 32'h0000_CAFE);
    issue(5'd0, 32'h0000_0000, 1'b1, 3'b010);
    respond(32'h1111_1111);
    check("x0ld_we", {31'd0, rf_we}, 32'd0);
    check("x0ld_ret", instret, 32'd14);

    // Stray read response while idle
    check("perr_pre", {31'd0, proto_err}, 32'd0);
    respond(32'h2222_2222);
    check("perr_set", {31'd0, proto_err}, 32'd1);
    check("perr_we", {31'd0, rf_we}, 32'd0);
    check("perr_ret", instret, 32'd14);
    tick();
    tick();
    check("perr_sticky", {31'd0, proto_err}, 32'd1);

    // Reset while a load is outstanding discards it
    issue(5'd4, 32'h0000_0200, 1'b1, 3'b010);
    check("rstld_stall", {31'd0, ex_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("rstld_async", instret, 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h3333_3333;
    tick();
    dmem_rvalid = 1'b0;
    rst = 1'b0;
    tick();
    check("rstld_we", {31'd0, rf_we}, 32'd0);
    check("rstld_ret", instret, 32'd0);
    check("rstld_ready", {31'd0, ex_ready}, 32'd1);
    check("rstld_perr", {31'd0, proto_err}, 32'd0);
    issue(5'd6, 32'h0000_0066, 1'b0, 3'd0);
    check("rstld_idle_we", {31'd0, rf_we}, 32'd1);
    check("rstld_idle_ret", instret, 32'd1);

    // Retire counter wraps
    force dut.instret_q = 32'hFFFF_FFFF;
    tick();
    release dut.instret_q;
    tick();
    check("wrap_pre", instret, 32'hFFFF_FFFF);
    issue(5'd1, 32'h0000_0001, 1'b0, 3'd0);
    check("wrap_0", instret, 32'd0);
    issue(5'd1, 32'h0000_0002, 1'b0, 3'd0);
    check("wrap_1", instret, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
